keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives a 4x4 matrix keypad: strobes one row low at a time, synchronizes the
//  active-low column inputs and locates a pressed key. Produces key_pressed plus
//  one-hot row_idx/col_idx for the downstream keypad debouncer.
//  Sits between the FPGA keypad pins and the debouncer.
//  Scanning freezes on the pressed row while a key is held.
// PARAMETERS
//  SETTLE_CYCLES  3000                         clocks each row is driven before sampling (~1 ms @ 3 MHz); must be >= 3
//  CNT_W          $clog2(SETTLE_CYCLES+1)      settle counter width (derived)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous, active-low reset
//  cols         in   4  raw column pins, active-low (external pull-ups), asynchronous
//  rows         out  4  row drive, active-low, exactly one bit low at all times
//  key_pressed  out  1  high while a key is located and its column still reads low
//  row_idx      out  4  one-hot row of located key; 4'b0000 when key_pressed=0
//  col_idx      out  4  one-hot column of located key; 4'b0000 when key_pressed=0
// BEHAVIOUR
//  Reset:
//   - rows=4'b1110 (row 0); key_pressed=0; row_idx=col_idx=4'b0000
//   - col sync regs=4'b1111; state=SETTLE; settle cnt=0; cur_row=0
//  Synchronizer: 2-FF on cols -> col_s. All decisions use col_s only.
//  FSM states:
//   - SETTLE: drive cur_row; cnt increments each clk.
//     - On cnt==SETTLE_CYCLES-1, evaluate col_s.
//     - If any bit low: go to HOLD; latch row_idx=1<<cur_row, col_idx=selected column; key_pressed=1.
//     - Else: cur_row=cur_row+1 (wraps 3->0); cnt=0; stay in SETTLE.
//     - Outputs update on the clock edge following the evaluation cycle (1-cycle latency).
//   - HOLD: rows keep driving cur_row; cnt is idle.
//     - Each cycle checks col_s bit of the latched column.
//     - If high: next cycle key_pressed=0, row_idx=col_idx=0, cur_row advances (wrap), cnt=0, state=SETTLE.
//     - Other columns going low/high in HOLD are ignored; col_idx never changes within one HOLD.
//  Column selection at evaluation: lowest-index low bit of col_s (col 0 highest priority).
//  rows is registered and changes only on row advance. One-hot invariant on rows is never violated, including across reset.
//  Reset asserted mid-scan or mid-HOLD returns immediately to reset values. No partial state survives.
//  cnt never exceeds SETTLE_CYCLES-1. Wrap after row 3 is to row 0 with no idle gap.
// CONFIGURATION
//  Macro KEYPAD_GHOST_REJECT_EN:
//   - Defined: at SETTLE evaluation, if more than one col_s bit is low, treat as no key and advance to next row.
//     In HOLD, extra low columns are still ignored.
//   - Undefined: multiple low columns resolve to the lowest index. No rejection.
// STRUCTURE
//  keypad_pkg:
//   - NUM_ROWS=4, NUM_COLS=4
//   - typedef enum logic {SETTLE, HOLD} scan_state_t
//   - function lowest_onehot(logic [3:0]) -> logic [3:0]
//   - function popcount4 (used under KEYPAD_GHOST_REJECT_EN)
//  Sub-module keypad_col_sync:
//   - 4-bit 2-FF synchronizer, reset to 4'b1111, shared with other pin inputs.
//  Top: FSM, settle counter, row register, output registers.
// TESTING (bench uses SETTLE_CYCLES=4; keypad model pulls col low when its row is low and key closed)
//  1. No key for 40 clks -> rows cycles 1110,1101,1011,0111,1110 every 4 clks; key_pressed stays 0.
//  2. Close key r2/c1 -> within one full scan key_pressed=1, row_idx=0100, col_idx=0010, rows frozen at 1011.
//  3. Release r2/c1 in HOLD -> 2 sync clks + 1 later key_pressed=0, idx=0; next row drive 0111.
//  4. Close r1/c0 and r1/c3 together -> col_idx=0001. With KEYPAD_GHOST_REJECT_EN: key_pressed stays 0, scan continues.
//  5. Hold r0/c2, then also press r0/c3, then release c2 -> col_idx stays 0100 until c2 high, then key_pressed=0.
//  6. Assert rst_n=0 during HOLD -> same cycle rows=1110, key_pressed=0, idx=0; resumes scan after release.
//  Check every cycle: rows has exactly one zero; idx are 0 or one-hot; idx==0 iff key_pressed==0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// popcount4 is only used when KEYPAD_GHOST_REJECT_EN is defined.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS);

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } scan_state_t;

    // Isolates the lowest set bit; column 0 wins when several are set.
    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        return v & 4'(~v + 4'd1);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for asynchronous active-low pin inputs.
// Resets to all-ones, the idle level of pulled-up pins.
module keypad_col_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: strobes rows low, locates a key and freezes on it while held.
// Define KEYPAD_GHOST_REJECT_EN to drop evaluations where several columns read low.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] cols,
    output logic [NUM_ROWS-1:0] rows,
    output logic                key_pressed,
    output logic [NUM_ROWS-1:0] row_idx,
    output logic [NUM_COLS-1:0] col_idx
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    cur_row_q, cur_row_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                key_pressed_q, key_pressed_d;
    logic [NUM_ROWS-1:0] row_idx_q, row_idx_d;
    logic [NUM_COLS-1:0] col_idx_q, col_idx_d;

    logic [NUM_COLS-1:0] col_s;
    logic [NUM_COLS-1:0] col_low;
    logic                key_found;

    keypad_col_sync #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cols),
        .q_o   (col_s)
    );

    assign col_low = ~col_s;

`ifdef KEYPAD_GHOST_REJECT_EN
    assign key_found = (popcount4(col_low) == 3'd1);
`else
    assign key_found = |col_low;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SETTLE;
            cnt_q         <= '0;
            cur_row_q     <= '0;
            rows_q        <= 4'b1110;
            key_pressed_q <= 1'b0;
            row_idx_q     <= '0;
            col_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_row_q     <= cur_row_d;
            rows_q        <= rows_d;
            key_pressed_q <= key_pressed_d;
            row_idx_q     <= row_idx_d;
            col_idx_q     <= col_idx_d;
        end
    end

    // Scan/hold sequencing; rows_d follows cur_row_d so the drive moves only on row advance.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_row_d     = cur_row_q;
        key_pressed_d = key_pressed_q;
        row_idx_d     = row_idx_q;
        col_idx_d     = col_idx_q;

        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (key_found) begin
                        state_d       = HOLD;
                        key_pressed_d = 1'b1;
                        row_idx_d     = NUM_ROWS'(1) << cur_row_q;
                        col_idx_d     = lowest_onehot(col_low);
                    end else begin
                        cur_row_d = cur_row_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // Only the latched column matters; others are ignored until release.
                if ((col_low & col_idx_q) == '0) begin
                    state_d       = SETTLE;
                    cnt_d         = '0;
                    cur_row_d     = cur_row_q + ROW_W'(1);
                    key_pressed_d = 1'b0;
                    row_idx_d     = '0;
                    col_idx_d     = '0;
                end
            end
        endcase

        rows_d = ~(NUM_ROWS'(1) << cur_row_d);
    end

    assign rows        = rows_q;
    assign key_pressed = key_pressed_q;
    assign row_idx     = row_idx_q;
    assign col_idx     = col_idx_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4 and a passive keypad matrix model.
// Build with KEYPAD_GHOST_REJECT_EN defined to exercise the ghost-rejection variant.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_pressed;
    logic [3:0] row_idx;
    logic [3:0] col_idx;

    logic [3:0][3:0] keys;   // keys[row][col] = 1 when closed

    int checks;
    int failures;

    keypad_scanner #(
        .SETTLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cols        (cols),
        .rows        (rows),
        .key_pressed (key_pressed),
        .row_idx     (row_idx),
        .col_idx     (col_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A closed key shorts its column to its row; pull-ups keep other columns high.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && !rows[r]) cols[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_kp(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (key_pressed !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(key_pressed), 32'(lvl));
    endtask

    always @(negedge clk) begin
        check("inv_rows_one_low", 32'($countones(~rows)), 32'd1);
        check("inv_row_idx_oh0", 32'($onehot0(row_idx)), 32'd1);
        check("inv_col_idx_oh0", 32'($onehot0(col_idx)), 32'd1);
        check("inv_row_idx_vs_kp", 32'(row_idx == 4'b0000), 32'(!key_pressed));
        check("inv_col_idx_vs_kp", 32'(col_idx == 4'b0000), 32'(!key_pressed));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] row_pat [4];
        logic       seen;
        row_pat[0] = 4'b1110;
        row_pat[1] = 4'b1101;
        row_pat[2] = 4'b1011;
        row_pat[3] = 4'b0111;

        checks   = 0;
        failures = 0;
        keys     = '0;
        rst_n    = 1'b0;
        tick(3);
        check("reset_rows", 32'(rows), 32'h0E);
        check("reset_kp", 32'(key_pressed), 32'd0);
        check("reset_row_idx", 32'(row_idx), 32'd0);
        check("reset_col_idx", 32'(col_idx), 32'd0);
        rst_n = 1'b1;

        // 1: idle scan, each row held for 4 clocks, wrapping 3 -> 0
        for (int i = 0; i < 40; i++) begin
            check("idle_rows", 32'(rows), 32'(row_pat[(i / 4) % 4]));
            check("idle_kp", 32'(key_pressed), 32'd0);
            tick(1);
        end

        // 2: close r2/c1
        keys[2][1] = 1'b1;
        wait_kp(1'b1, 24, "r2c1_detect");
        check("r2c1_row_idx", 32'(row_idx), 32'h4);
        check("r2c1_col_idx", 32'(col_idx), 32'h2);
        check("r2c1_rows", 32'(rows), 32'h0B);
        tick(10);
        check("r2c1_rows_frozen", 32'(rows), 32'h0B);
        check("r2c1_kp_held", 32'(key_pressed), 32'd1);

        // 3: release in HOLD: two sync clocks then one output clock
        keys[2][1] = 1'b0;
        tick(2);
        check("rel_kp_still", 32'(key_pressed), 32'd1);
        tick(1);
        check("rel_kp", 32'(key_pressed), 32'd0);
        check("rel_row_idx", 32'(row_idx), 32'd0);
        check("rel_col_idx", 32'(col_idx), 32'd0);
        check("rel_rows_next", 32'(rows), 32'h07);

        // 4: r1/c0 and r1/c3 together
        keys[1][0] = 1'b1;
        keys[1][3] = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            seen |= key_pressed;
            tick(1);
        end
        check("ghost_rejected", 32'(seen), 32'd0);
`else
        wait_kp(1'b1, 24, "multi_detect");
        check("multi_row_idx", 32'(row_idx), 32'h2);
        check("multi_col_idx", 32'(col_idx), 32'h1);
`endif
        keys = '0;
        wait_kp(1'b0, 10, "multi_release");

        // 5: hold r0/c2, add r0/c3, release c2
        keys[0][2] = 1'b1;
        wait_kp(1'b1, 24, "r0c2_detect");
        check("r0c2_row_idx", 32'(row_idx), 32'h1);
        check("r0c2_col_idx", 32'(col_idx), 32'h4);
        keys[0][3] = 1'b1;
        tick(5);
        check("r0c2_col_locked", 32'(col_idx), 32'h4);
        check("r0c2_kp_locked", 32'(key_pressed), 32'd1);
        keys[0][2] = 1'b0;
        tick(2);
        check("r0c2_rel_still", 32'(key_pressed), 32'd1);
        check("r0c2_rel_col_still", 32'(col_idx), 32'h4);
        tick(1);
        check("r0c2_rel_kp", 32'(key_pressed), 32'd0);
        check("r0c2_rel_col", 32'(col_idx), 32'd0);
        keys = '0;
        wait_kp(1'b0, 10, "r0c3_release");

        // 6: reset while in HOLD
        keys[1][1] = 1'b1;
        wait_kp(1'b1, 24, "r1c1_detect");
        check("r1c1_row_idx", 32'(row_idx), 32'h2);
        rst_n = 1'b0;
        #1;
        check("midhold_rst_rows", 32'(rows), 32'h0E);
        check("midhold_rst_kp", 32'(key_pressed), 32'd0);
        check("midhold_rst_row_idx", 32'(row_idx), 32'd0);
        check("midhold_rst_col_idx", 32'(col_idx), 32'd0);
        tick(2);
        keys  = '0;
        rst_n = 1'b1;
        check("resume_rows0", 32'(rows), 32'h0E);
        tick(4);
        check("resume_rows1", 32'(rows), 32'h0D);
        tick(4);
        check("resume_rows2", 32'(rows), 32'h0B);
        check("resume_kp", 32'(key_pressed), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
